// File: rtl/spi_mem_writer_pkg.sv
// spi_mem_writer_pkg: word/address geometry shared by the SPI memory read and write paths.
package spi_mem_writer_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 12;

    function automatic int ctr_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    localparam int BIT_CTR_W = ctr_w(DEF_DATA_W);
    localparam logic [DEF_ADDR_W-1:0] ADDR_MAX = '1;
endpackage

// File: rtl/spi_word_deser.sv
// spi_word_deser: MSB-first shift register with a down-counting bit position.
// o_done flags the sel edge that carries the final bit of a word; o_word is that completed word.
module spi_word_deser
    import spi_mem_writer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_sel,
    input  logic              i_si,
    input  logic              i_reset_flag,
    output logic [DATA_W-1:0] o_word,
    output logic              o_done
);
    localparam int CW = ctr_w(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic [CW-1:0]     r_cnt;
    logic [DATA_W-2:0] r_shreg;

    assign o_word = {r_shreg, i_si};
    assign o_done = i_sel && (r_cnt == '0);

    // Counter and shift register hold while sel is low so gapped words stay intact.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= LAST;
            r_shreg <= '0;
        end else if (i_reset_flag) begin
            r_cnt   <= LAST;
            r_shreg <= '0;
        end else if (i_sel) begin
            r_shreg <= o_word[DATA_W-2:0];
            r_cnt   <= o_done ? LAST : r_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/spi_mem_writer.sv
// spi_mem_writer: turns the SPI bitstream into auto-incrementing single-cycle memory writes.
// WRAP selects whether the end of memory stops writing (0) or rolls over to address 0 (1).
module spi_mem_writer
    import spi_mem_writer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter bit WRAP   = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sel,
    input  logic              si,
    input  logic              reset_flag,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic              full
);
    logic [DATA_W-1:0] w_word;
    logic              w_done;
    logic              w_last;

    spi_word_deser #(.DATA_W(DATA_W)) u_deser (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_sel       (sel),
        .i_si        (si),
        .i_reset_flag(reset_flag),
        .o_word      (w_word),
        .o_done      (w_done)
    );

    assign w_last = &addr;

    // Address advances as the we cycle ends; at the top it either holds or wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_data <= '0;
            addr    <= '0;
            we      <= 1'b0;
            full    <= 1'b0;
        end else if (reset_flag) begin
            addr <= '0;
            we   <= 1'b0;
            full <= 1'b0;
        end else begin
            we <= w_done && !(full && !WRAP);
            if (w_done) wr_data <= w_word;
            if (we && !(w_last && !WRAP)) addr <= addr + 1'b1;
            if (we && w_last) full <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_mem_writer.sv
// tb_spi_mem_writer: scoreboard bench driving a hold-at-end and a wrapping instance with one bitstream.
module tb_spi_mem_writer;
    logic clk = 1'b0, reset_n = 1'b0, sel = 1'b0, si = 1'b0, reset_flag = 1'b0;
    logic [15:0] wd0, wd1;
    logic [11:0] a0, a1;
    logic we0, we1, f0, f1;
    int n_chk = 0, n_fail = 0;
    int cyc = 0, we_prev = 0, we_last = 0;
    logic [27:0] q0[$], q1[$];

    always #5 clk = ~clk;

    spi_mem_writer #(.DATA_W(16), .ADDR_W(12), .WRAP(1'b0)) u0 (
        .clk(clk), .reset_n(reset_n), .sel(sel), .si(si), .reset_flag(reset_flag),
        .wr_data(wd0), .addr(a0), .we(we0), .full(f0));

    spi_mem_writer #(.DATA_W(16), .ADDR_W(12), .WRAP(1'b1)) u1 (
        .clk(clk), .reset_n(reset_n), .sel(sel), .si(si), .reset_flag(reset_flag),
        .wr_data(wd1), .addr(a1), .we(we1), .full(f1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bits(input logic [15:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            sel = 1'b1;
            si  = w[i];
            tick();
        end
        sel = 1'b0;
    endtask

    task automatic expect_both(input logic [11:0] a, input logic [15:0] d);
        q0.push_back({a, d});
        q1.push_back({a, d});
    endtask

    task automatic rflag();
        reset_flag = 1'b1;
        tick();
        reset_flag = 1'b0;
    endtask

    // Monitor: every observed write strobe must match the head of its queue.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (we0) begin
            we_prev = we_last;
            we_last = cyc;
            if (q0.size() == 0) chk("u0_unexpected_we", {4'h0, a0, wd0}, 32'hFFFF_FFFF);
            else chk("u0_write", {4'h0, a0, wd0}, {4'h0, q0.pop_front()});
        end
        if (we1) begin
            if (q1.size() == 0) chk("u1_unexpected_we", {4'h0, a1, wd1}, 32'hFFFF_FFFF);
            else chk("u1_write", {4'h0, a1, wd1}, {4'h0, q1.pop_front()});
        end
    end

    initial begin
        logic [15:0] d;
        #3;
        chk("rst_wr_data", wd0, 0);
        chk("rst_addr", a0, 0);
        chk("rst_we", we0, 0);
        chk("rst_full", f0, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        tick();

        // Continuous word, write then address increment
        expect_both(12'h000, 16'hA5C3);
        send_bits(16'hA5C3, 15, 0);
        chk("t2_we_high", we0, 1);
        chk("t2_addr_during_we", a0, 12'h000);
        tick();
        chk("t2_we_low", we0, 0);
        chk("t2_addr_inc", a0, 12'h001);

        // Async reset mid-word
        send_bits(16'h5A5A, 15, 9);
        reset_n = 1'b0;
        #1;
        chk("t1_async_wr_data", wd0, 0);
        chk("t1_async_addr", a0, 0);
        chk("t1_async_we", we0, 0);
        chk("t1_async_full", f0, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        expect_both(12'h000, 16'h5A5A);
        send_bits(16'h5A5A, 15, 0);
        tick();

        // Gapped word, then back-to-back words
        rflag();
        expect_both(12'h000, 16'h1234);
        send_bits(16'h1234, 15, 8);
        repeat (5) tick();
        send_bits(16'h1234, 7, 0);
        tick();
        expect_both(12'h001, 16'hBEEF);
        expect_both(12'h002, 16'h0001);
        send_bits(16'hBEEF, 15, 0);
        send_bits(16'h0001, 15, 0);
        chk("t3_we_spacing", we_last - we_prev, 16);
        tick();
        chk("t3_addr_after", a0, 12'h003);

        // Abort a partial word, then a clean word
        rflag();
        send_bits(16'hB6DB, 15, 7);
        rflag();
        expect_both(12'h000, 16'hFFFF);
        send_bits(16'hFFFF, 15, 0);
        tick();

        // reset_flag on the completing edge discards the word
        rflag();
        send_bits(16'h1111, 15, 1);
        sel = 1'b1;
        si = 1'b1;
        reset_flag = 1'b1;
        tick();
        reset_flag = 1'b0;
        sel = 1'b0;
        tick();
        chk("t4_discard_no_we", we0, 0);
        chk("t4_discard_addr", a0, 12'h000);
        expect_both(12'h000, 16'h2222);
        send_bits(16'h2222, 15, 0);
        tick();

        // reset_flag during the we cycle of a write at 0x005
        rflag();
        for (int k = 0; k < 5; k++) begin
            expect_both(12'(k), 16'h0100 + 16'(k));
            send_bits(16'h0100 + 16'(k), 15, 0);
        end
        expect_both(12'h005, 16'h0C05);
        send_bits(16'h0C05, 15, 0);
        chk("t6_we_at_5", we0, 1);
        chk("t6_addr_5", a0, 12'h005);
        reset_flag = 1'b1;
        tick();
        reset_flag = 1'b0;
        chk("t6_we_low", we0, 0);
        chk("t6_addr_cleared", a0, 12'h000);
        chk("t6_full_clear", f0, 0);

        // Fill the whole memory in both end-of-memory modes
        rflag();
        for (int i = 0; i < 4096; i++) begin
            d = (16'(i) * 16'h0101) ^ 16'h5A00;
            expect_both(12'(i), d);
            send_bits(d, 15, 0);
        end
        tick();
        chk("t5_full_hold", f0, 1);
        chk("t5_full_wrap", f1, 1);
        chk("t5_addr_hold", a0, 12'hFFF);
        chk("t5_addr_wrap", a1, 12'h000);
        q1.push_back({12'h000, 16'hCAFE});
        send_bits(16'hCAFE, 15, 0);
        chk("t5_hold_dropped", we0, 0);
        chk("t5_hold_wr_data", wd0, 16'hCAFE);
        chk("t5_hold_addr", a0, 12'hFFF);
        chk("t5_wrap_we", we1, 1);
        tick();
        chk("t5_wrap_addr_next", a1, 12'h001);
        chk("t5_wrap_full_kept", f1, 1);
        chk("t5_hold_addr_kept", a0, 12'hFFF);

        tick();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
